// File: rtl/odometer_pkg.sv
// odometer_pkg: state encoding and ring-select codes shared by the odometer sequencer
package odometer_pkg;
   typedef enum logic [2:0] {S_IDLE, S_STRESS, S_GAP_IN, S_SETTLE, S_MEASURE, S_GAP_OUT} state_t;
   localparam logic [1:0] SEL_CFG_INV  = 2'd0;
   localparam logic [1:0] SEL_CFG_NAND = 2'd1;
   localparam logic [1:0] SEL_CFG_NOR  = 2'd2;
   localparam logic [1:0] SEL_CFG_RSVD = 2'd3;
   // one-hot {nor, nand, inv}; the reserved code selects no ring
   function automatic logic [2:0] sel_decode(input logic [1:0] cfg);
      return {cfg == SEL_CFG_NOR, cfg == SEL_CFG_NAND, cfg == SEL_CFG_INV};
   endfunction
endpackage

// File: rtl/odometer_sat_cnt.sv
// odometer_sat_cnt: saturating edge counter with synchronous clear; exposes its next value
module odometer_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt_nxt
);
   logic [CNT_W-1:0] r_cnt;
   assign o_cnt_nxt = i_clr ? '0 : (i_inc && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
   always_ff @(posedge i_clk) r_cnt <= i_rst ? '0 : o_cnt_nxt;
endmodule

// File: rtl/odometer_meas_seq.sv
// odometer_meas_seq: stress/measure sequencer for the stressed and reference ring-oscillator pair
module odometer_meas_seq
   import odometer_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int WINDOW      = 1024,
   parameter int SETTLE_CYC  = 16,
   parameter int GAP_CYC     = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_stress_en,
   input  logic             i_meas_trig,
   input  logic [1:0]       i_sel_cfg,
   input  logic             i_ac_dc_cfg,
   input  logic             i_stress_edge,
   input  logic             i_ref_edge,
   output logic             o_sel_inv,
   output logic             o_sel_nand,
   output logic             o_sel_nor,
   output logic             o_start,
   output logic             o_ac_dc,
   output logic             o_meas_stress,
   output logic             o_en_rosc,
   output logic             o_en_power_rosc_stress,
   output logic [CNT_W-1:0] o_stress_cnt,
   output logic [CNT_W-1:0] o_ref_cnt,
   output logic             o_done,
   output logic             o_busy,
   output logic             o_timeout
);
   localparam int T_SG = SETTLE_CYC > GAP_CYC ? SETTLE_CYC : GAP_CYC;
   localparam int TMAX = TIMEOUT_CYC > T_SG ? TIMEOUT_CYC : T_SG;
   localparam int TW   = $clog2(TMAX + 1);
   state_t r_state, w_state_n;
   logic [TW-1:0] r_tmr, w_tmr_ld;
   logic [CNT_W-1:0] r_stress_cnt, r_ref_cnt, w_stress_nxt, w_ref_nxt;
   logic [2:0] r_sel;
   logic r_trig_q, r_pwr_prev, r_done, r_timeout, r_ac_dc;
   logic w_rest, w_accept, w_tmr_zero, w_meas, w_hit, w_abort;
   assign w_rest     = r_state == S_IDLE || r_state == S_STRESS;
   assign w_accept   = w_rest && i_meas_trig && !r_trig_q && i_sel_cfg != SEL_CFG_RSVD;
   assign w_tmr_zero = r_tmr == '0;
   assign w_meas     = r_state == S_MEASURE;
   assign w_hit      = w_meas && i_ref_edge && w_ref_nxt == CNT_W'(WINDOW);
   assign w_abort    = w_meas && w_tmr_zero && !w_hit;
   // one timer serves every timed state; reload on each state change
   assign w_tmr_ld = w_state_n == S_SETTLE  ? TW'(SETTLE_CYC - 1) :
                     w_state_n == S_MEASURE ? TW'(TIMEOUT_CYC - 1) : TW'(GAP_CYC - 1);
   odometer_sat_cnt #(.CNT_W(CNT_W)) u_stress_cnt (
      .i_clk     (i_clk),
      .i_rst     (i_reset),
      .i_clr     (r_state == S_SETTLE),
      .i_inc     (w_meas && i_stress_edge),
      .o_cnt_nxt (w_stress_nxt)
   );
   odometer_sat_cnt #(.CNT_W(CNT_W)) u_ref_cnt (
      .i_clk     (i_clk),
      .i_rst     (i_reset),
      .i_clr     (r_state == S_SETTLE),
      .i_inc     (w_meas && i_ref_edge),
      .o_cnt_nxt (w_ref_nxt)
   );
   always_ff @(posedge i_clk) r_state <= i_reset ? S_IDLE : w_state_n;
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE, S_STRESS: w_state_n = w_accept ? S_GAP_IN : i_stress_en ? S_STRESS : S_IDLE;
         S_GAP_IN:         w_state_n = w_tmr_zero ? S_SETTLE : S_GAP_IN;
         S_SETTLE:         w_state_n = w_tmr_zero ? S_MEASURE : S_SETTLE;
         S_MEASURE:        w_state_n = (w_hit || w_tmr_zero) ? S_GAP_OUT : S_MEASURE;
         S_GAP_OUT:        w_state_n = !w_tmr_zero ? S_GAP_OUT : i_stress_en ? S_STRESS : S_IDLE;
         default:          w_state_n = S_IDLE;
      endcase
   end
   always_comb begin
      o_start                = r_state inside {S_STRESS, S_SETTLE, S_MEASURE};
      o_meas_stress          = r_state inside {S_SETTLE, S_MEASURE};
      o_en_rosc              = r_state inside {S_SETTLE, S_MEASURE};
      o_en_power_rosc_stress = r_state inside {S_STRESS, S_SETTLE, S_MEASURE, S_GAP_OUT} ||
                               (r_state == S_GAP_IN && r_pwr_prev);
      o_busy                 = !w_rest;
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tmr        <= '0;
         r_trig_q     <= 1'b0;
         r_pwr_prev   <= 1'b0;
         r_sel        <= '0;
         r_ac_dc      <= 1'b0;
         r_stress_cnt <= '0;
         r_ref_cnt    <= '0;
         r_done       <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_tmr    <= w_state_n != r_state ? w_tmr_ld : w_tmr_zero ? r_tmr : r_tmr - 1'b1;
         r_trig_q <= i_meas_trig;
         if (w_rest && w_state_n != r_state) begin
            r_sel      <= sel_decode(i_sel_cfg);
            r_ac_dc    <= i_ac_dc_cfg;
            r_pwr_prev <= r_state == S_STRESS;
         end
         if (w_hit) begin
            r_stress_cnt <= w_stress_nxt;
            r_ref_cnt    <= w_ref_nxt;
         end
         r_done    <= w_hit;
         r_timeout <= w_abort || (r_timeout && !w_accept);
      end
   end
   assign {o_sel_nor, o_sel_nand, o_sel_inv} = r_sel;
   assign o_ac_dc      = r_ac_dc;
   assign o_stress_cnt = r_stress_cnt;
   assign o_ref_cnt    = r_ref_cnt;
   assign o_done       = r_done;
   assign o_timeout    = r_timeout;
endmodule

// File: tb/tb_odometer_meas_seq.sv
// tb_odometer_meas_seq: directed sequence with random edge streams checked against a window-sum model
`timescale 1ns/1ps
module tb_odometer_meas_seq;
   localparam int G = 2, S = 4, W = 8, T = 50;
   localparam int LEN = 1 + G + S + T + G + 2;
   logic clk = 1'b0, rst = 1'b1, stress_en = 1'b0, trig = 1'b0, ac_dc_cfg = 1'b0, se = 1'b0, re = 1'b0;
   logic [1:0] sel_cfg = 2'd0;
   logic a_inv, a_nand, a_nor, a_start, a_acdc, a_meas, a_en, a_pwr, a_done, a_busy, a_to;
   logic b_inv, b_nand, b_nor, b_start, b_acdc, b_meas, b_en, b_pwr, b_done, b_busy, b_to;
   logic [15:0] a_sc, a_rc;
   logic [3:0] b_sc, b_rc;
   int n_chk = 0, n_fail = 0;
   int prev_sc = 0, prev_rc = 0, prev_to = 0;
   odometer_meas_seq #(.CNT_W(16), .WINDOW(W), .SETTLE_CYC(S), .GAP_CYC(G), .TIMEOUT_CYC(T)) dut (
      .i_clk(clk), .i_reset(rst), .i_stress_en(stress_en), .i_meas_trig(trig), .i_sel_cfg(sel_cfg),
      .i_ac_dc_cfg(ac_dc_cfg), .i_stress_edge(se), .i_ref_edge(re),
      .o_sel_inv(a_inv), .o_sel_nand(a_nand), .o_sel_nor(a_nor), .o_start(a_start), .o_ac_dc(a_acdc),
      .o_meas_stress(a_meas), .o_en_rosc(a_en), .o_en_power_rosc_stress(a_pwr),
      .o_stress_cnt(a_sc), .o_ref_cnt(a_rc), .o_done(a_done), .o_busy(a_busy), .o_timeout(a_to)
   );
   odometer_meas_seq #(.CNT_W(4), .WINDOW(W), .SETTLE_CYC(S), .GAP_CYC(G), .TIMEOUT_CYC(T)) dut4 (
      .i_clk(clk), .i_reset(rst), .i_stress_en(stress_en), .i_meas_trig(trig), .i_sel_cfg(sel_cfg),
      .i_ac_dc_cfg(ac_dc_cfg), .i_stress_edge(se), .i_ref_edge(re),
      .o_sel_inv(b_inv), .o_sel_nand(b_nand), .o_sel_nor(b_nor), .o_start(b_start), .o_ac_dc(b_acdc),
      .o_meas_stress(b_meas), .o_en_rosc(b_en), .o_en_power_rosc_stress(b_pwr),
      .o_stress_cnt(b_sc), .o_ref_cnt(b_rc), .o_done(b_done), .o_busy(b_busy), .o_timeout(b_to)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_quiet(input string tag);
      chk({tag, " start"}, 32'(a_start), 0);
      chk({tag, " meas"}, 32'(a_meas), 0);
      chk({tag, " en_rosc"}, 32'(a_en), 0);
      chk({tag, " pwr"}, 32'(a_pwr), 0);
      chk({tag, " busy"}, 32'(a_busy), 0);
      chk({tag, " done"}, 32'(a_done), 0);
      chk({tag, " sel"}, 32'({a_nor, a_nand, a_inv}), 0);
   endtask
   // mode 0: periodic edges, 1: stress every cycle, 2: random, 3: no reference edges
   task automatic measure(input int mode);
      logic se_a [LEN];
      logic re_a [LEN];
      logic tr_a [LEN];
      int sc, rc, hit, fin, ms, nsc, nsc4, nrc, ex_to;
      ms = 1 + G + S;
      for (int n = 0; n < LEN; n++) begin
         se_a[n] = mode == 0 ? n % 2 == 1 : mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
         re_a[n] = mode == 3 ? 1'b0 : mode == 2 ? $urandom_range(0, 2) == 0 : n % 4 == 3;
      end
      sc = 0;
      rc = 0;
      hit = -1;
      for (int m = 0; m < T; m++) begin
         sc += int'(se_a[ms + m]);
         rc += int'(re_a[ms + m]);
         if (rc == W) begin
            hit = ms + m;
            break;
         end
      end
      fin = hit >= 0 ? hit : ms + T - 1;
      for (int n = 0; n < LEN; n++) tr_a[n] = n == 0 ? 1'b1 : n <= fin ? 1'($urandom_range(0, 1)) : 1'b0;
      nsc  = hit >= 0 ? sc : prev_sc;
      nsc4 = nsc > 15 ? 15 : nsc;
      nrc  = hit >= 0 ? rc : prev_rc;
      ex_to = hit < 0 ? 1 : 0;
      for (int n = 0; n < LEN; n++) begin
         trig = tr_a[n];
         se = se_a[n];
         re = re_a[n];
         chk("busy", 32'(a_busy), 32'(n >= 1 && n <= fin + G));
         chk("meas_stress", 32'(a_meas), 32'(n >= 1 + G && n <= fin));
         chk("en_rosc", 32'(a_en), 32'(n >= 1 + G && n <= fin));
         chk("start", 32'(a_start), 32'(!(n >= 1 && n <= G) && !(n > fin && n <= fin + G)));
         if (n <= fin) chk("pwr", 32'(a_pwr), 1);
         chk("done", 32'(a_done), 32'(hit >= 0 && n == hit + 1));
         chk("done4", 32'(b_done), 32'(hit >= 0 && n == hit + 1));
         chk("timeout", 32'(a_to), n == 0 ? prev_to : n > fin ? ex_to : 0);
         chk("stress_cnt", 32'(a_sc), n > fin ? nsc : prev_sc);
         chk("ref_cnt", 32'(a_rc), n > fin ? nrc : prev_rc);
         chk("stress_cnt4", 32'(b_sc), n > fin ? nsc4 : (prev_sc > 15 ? 15 : prev_sc));
         chk("ref_cnt4", 32'(b_rc), n > fin ? nrc : prev_rc);
         step();
      end
      prev_sc = nsc;
      prev_rc = nrc;
      prev_to = ex_to;
   endtask
   initial begin
      step();
      step();
      chk_quiet("reset");
      chk("reset acdc", 32'(a_acdc), 0);
      chk("reset timeout", 32'(a_to), 0);
      chk("reset stress_cnt", 32'(a_sc), 0);
      chk("reset ref_cnt", 32'(a_rc), 0);
      rst = 1'b0;
      stress_en = 1'b1;
      sel_cfg = 2'd1;
      ac_dc_cfg = 1'b1;
      step();
      chk("stress sel", 32'({a_nor, a_nand, a_inv}), 32'h2);
      chk("stress acdc", 32'(a_acdc), 1);
      chk("stress start", 32'(a_start), 1);
      chk("stress pwr", 32'(a_pwr), 1);
      chk("stress meas", 32'(a_meas), 0);
      chk("stress busy", 32'(a_busy), 0);
      measure(0);
      measure(1);
      measure(3);
      measure(2);
      measure(0);
      trig = 1'b1;
      se = 1'b1;
      re = 1'b1;
      step();
      trig = 1'b0;
      repeat (G + S + 3) step();
      chk("mid meas", 32'(a_meas), 1);
      rst = 1'b1;
      step();
      chk_quiet("mid reset");
      chk("mid reset stress_cnt", 32'(a_sc), 0);
      chk("mid reset ref_cnt", 32'(a_rc), 0);
      chk("mid reset stress_cnt4", 32'(b_sc), 0);
      chk("mid reset timeout", 32'(a_to), 0);
      rst = 1'b0;
      stress_en = 1'b0;
      se = 1'b0;
      re = 1'b0;
      step();
      chk_quiet("post reset idle");
      sel_cfg = 2'd3;
      trig = 1'b1;
      step();
      chk_quiet("rsvd idle trig");
      trig = 1'b0;
      stress_en = 1'b1;
      step();
      chk("rsvd stress start", 32'(a_start), 1);
      chk("rsvd stress sel", 32'({a_nor, a_nand, a_inv}), 0);
      trig = 1'b1;
      step();
      chk("rsvd trig busy", 32'(a_busy), 0);
      chk("rsvd trig start", 32'(a_start), 1);
      step();
      chk("rsvd hold busy", 32'(a_busy), 0);
      trig = 1'b0;
      sel_cfg = 2'd2;
      step();
      trig = 1'b1;
      step();
      chk("nor accept busy", 32'(a_busy), 1);
      chk("nor accept start", 32'(a_start), 0);
      chk("nor accept sel", 32'({a_nor, a_nand, a_inv}), 32'h4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/odometer_meas_seq.md
Name: odometer_meas_seq

Overview:
- Synchronous sequencer for the odometer ring-oscillator pair (stressed ROSC plus reference ROSC).
- Holds the stressed ring in DC/AC stress. On a measurement trigger it interrupts stress, enables both rings in measure mode and counts edges of each over a window set by the reference ring.
- Reports both counts with a done flag, then returns to stress.
- Sits between the scan-loaded configuration bits and the ROSC blocks, replacing hand-driven START/MEAS_STRESS/EN_ROSC control.

Parameters:
- CNT_W, 16, width of both edge counters.
- WINDOW, 1024, reference-edge count that ends a measurement (1 .. 2^CNT_W-1).
- SETTLE_CYC, 16, CLK cycles rings run in measure mode before counting starts (>=1).
- GAP_CYC, 4, CLK cycles with START low between stress and measure, and between measure and stress (>=1).
- TIMEOUT_CYC, 65535, CLK cycles allowed in MEASURE before abort.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- STRESS_EN  in  1  level; 1 = stress the ring while not measuring
- MEAS_TRIG  in  1  level; a rising edge (registered compare) requests one measurement
- SEL_CFG  in  2  ring type: 0 INV, 1 NAND, 2 NOR, 3 reserved
- AC_DC_CFG  in  1  1 = AC stress (VCO-toggled), 0 = DC
- STRESS_EDGE  in  1  one-cycle pulse per stressed-ring edge, pre-synchronised to CLK
- REF_EDGE  in  1  one-cycle pulse per reference-ring edge, pre-synchronised to CLK
- SEL_INV / SEL_NAND / SEL_NOR  out  1 each  one-hot ring select
- START  out  1  ring start/stress drive
- AC_DC  out  1  stress mode to ROSC
- MEAS_STRESS  out  1  measure mode; also powers the reference ring
- EN_ROSC  out  1  oscillation enable
- EN_POWER_ROSC_STRESS  out  1  stressed-ring power
- STRESS_CNT  out  CNT_W  last stressed-ring count
- REF_CNT  out  CNT_W  last reference-ring count
- DONE  out  1  one-cycle pulse when a result is latched
- BUSY  out  1  high in GAP_IN/SETTLE/MEASURE/GAP_OUT
- TIMEOUT  out  1  sticky; set on an aborted measurement, cleared by the next trigger accepted

Behaviour:
- Reset: state IDLE. All outputs 0, counters 0, trigger edge register 0.
- SEL_*: decoded from SEL_CFG, latched only when leaving IDLE or STRESS. SEL_CFG=3 latches all-zero select and triggers are ignored.
- AC_DC: latched with SEL.
- States:
  - IDLE: all ring controls 0. STRESS_EN=1 -> STRESS.
  - STRESS: EN_POWER_ROSC_STRESS=1, START=1, MEAS_STRESS=0, EN_ROSC=0. STRESS_EN=0 -> IDLE.
  - Trigger edge in IDLE or STRESS (SEL valid) -> GAP_IN. Trigger wins over a simultaneous STRESS_EN drop.
  - GAP_IN: START=0, EN_POWER_ROSC_STRESS keeps its prior value, for GAP_CYC cycles -> SETTLE.
  - SETTLE: MEAS_STRESS=1, EN_ROSC=1, EN_POWER_ROSC_STRESS=1, START=1. Edges ignored and counters cleared. After SETTLE_CYC cycles -> MEASURE.
  - MEASURE: same outputs as SETTLE. Each STRESS_EDGE/REF_EDGE increments its counter by 1. Counters saturate at 2^CNT_W-1, never wrap.
    - On the cycle REF_EDGE brings the ref count to WINDOW: both counts, including edges that cycle, latch to STRESS_CNT/REF_CNT; DONE pulses the next cycle; -> GAP_OUT.
    - Simultaneous edges on both inputs both count.
  - Timeout: TIMEOUT_CYC cycles in MEASURE without reaching WINDOW -> TIMEOUT=1, outputs not updated, no DONE, -> GAP_OUT.
  - GAP_OUT: MEAS_STRESS=0, EN_ROSC=0, START=0 for GAP_CYC cycles -> STRESS if STRESS_EN else IDLE.
- Triggers arriving while BUSY are dropped, not queued.
- RESET mid-measurement: immediate return to reset values. No DONE pulse, results cleared.

Decomposition:
- Package odometer_pkg: state enum (IDLE, STRESS, GAP_IN, SETTLE, MEASURE, GAP_OUT) and SEL_CFG encoding constants.
- One sub-module, odometer_sat_cnt (CNT_W, clear, inc, saturating), instantiated twice.
- A single shared down-counter for GAP/SETTLE/TIMEOUT lives in the top.

Test Plan:
- Reset then STRESS_EN=1, SEL_CFG=1, AC_DC_CFG=1 -> within 1 cycle of leaving IDLE: SEL_NAND=1, AC_DC=1, START=1, EN_POWER_ROSC_STRESS=1, MEAS_STRESS=0.
- WINDOW=8, SETTLE_CYC=4, GAP_CYC=2. Trigger, REF_EDGE every 4 cycles, STRESS_EDGE every 2 -> DONE once, REF_CNT=8, STRESS_CNT=16±1, back in STRESS after 2 GAP cycles.
- Edges during SETTLE, and a second trigger mid-MEASURE -> edges not counted, second trigger ignored, exactly one DONE.
- CNT_W=4, STRESS_EDGE every cycle, WINDOW=8 -> STRESS_CNT=15 (saturated), REF_CNT=8.
- REF_EDGE held low, TIMEOUT_CYC=50 -> TIMEOUT=1 after 50 MEASURE cycles, no DONE, previous counts kept; next trigger clears TIMEOUT.
- RESET asserted in MEASURE; separately, SEL_CFG=3 with trigger -> all outputs 0 and IDLE next cycle; the trigger is ignored with state unchanged.
